// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: holds, bubbles, forwarding, boot and bridge waits.
// Optional build macro PIPE_HAZARD_PERF_EN enables saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int BOOT_CYCLES = 2,
    parameter int BUS_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_re,
    input  logic             id_rs2_re,
    input  logic [4:0]       ex_wr,
    input  logic             ex_rf_we,
    input  logic             ex_is_load,
    input  logic [4:0]       mem_wr,
    input  logic             mem_rf_we,
    input  logic [4:0]       wb_wr,
    input  logic             wb_rf_we,
    input  logic             ex_redirect,
    input  logic             mem_bus_req,
    input  logic             bus_ack,
    output logic             pc_hold,
    output logic             if_id_hold,
    output logic             id_ex_hold,
    output logic             ex_mem_hold,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic [1:0]       fwd_rs1_sel,
    output logic [1:0]       fwd_rs2_sel,
    output logic             bus_timeout,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] perf_load_stall,
    output logic [CNT_W-1:0] perf_bus_wait,
    output logic [CNT_W-1:0] perf_flush
);
    localparam logic [1:0] ST_BOOT = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_WAIT = 2'b10;
    localparam logic [1:0] ST_ERR  = 2'b11;

    localparam int BW = $clog2(BOOT_CYCLES + 1);
    localparam int WW = $clog2(BUS_TIMEOUT + 1);
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(BUS_TIMEOUT - 1);

    logic [1:0]    state_reg, state_next;
    logic [BW-1:0] boot_cnt_reg, boot_cnt_next;
    logic [WW-1:0] wait_cnt_reg, wait_cnt_next;

    logic       active, bus_stall, load_use;
    logic       st_bus, st_redir, st_load;
    logic [4:0] src_rs [2];
    logic       src_re [2];
    logic [1:0] src_fwd [2];

    assign active    = (state_reg == ST_RUN) || (state_reg == ST_WAIT);
    assign bus_stall = mem_bus_req & ~bus_ack;
    assign load_use  = ex_is_load & ex_rf_we & (ex_wr != 5'd0) &
                       ((id_rs1_re & (id_rs1 == ex_wr)) | (id_rs2_re & (id_rs2 == ex_wr)));

    // Effective (priority-resolved) events, shared by the outputs and the counters.
    assign st_bus   = active & bus_stall;
    assign st_redir = active & ~bus_stall & ex_redirect;
    assign st_load  = active & ~bus_stall & ~ex_redirect & load_use;

    assign src_rs[0] = id_rs1;
    assign src_rs[1] = id_rs2;
    assign src_re[0] = id_rs1_re;
    assign src_re[1] = id_rs2_re;

    // A load still in EX never forwards; the load-use stall covers that case.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                src_fwd[gi] = 2'b00;
                if (src_re[gi] && src_rs[gi] != 5'd0) begin
                    if (ex_rf_we && !ex_is_load && ex_wr == src_rs[gi])
                        src_fwd[gi] = 2'b01;
                    else if (mem_rf_we && mem_wr == src_rs[gi])
                        src_fwd[gi] = 2'b10;
                    else if (wb_rf_we && wb_wr == src_rs[gi])
                        src_fwd[gi] = 2'b11;
                end
            end
        end
    endgenerate

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            state_reg    <= ST_BOOT;
            boot_cnt_reg <= '0;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            boot_cnt_reg <= boot_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        boot_cnt_next = boot_cnt_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_BOOT: begin
                boot_cnt_next = boot_cnt_reg + 1'b1;
                if (boot_cnt_reg == BOOT_LAST)
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                if (bus_stall) begin
                    state_next    = ST_WAIT;
                    wait_cnt_next = WW'(1);
                end
            end
            ST_WAIT: begin
                if (bus_ack || !mem_bus_req)
                    state_next = ST_RUN;
                else if (wait_cnt_reg == WAIT_LAST)
                    state_next = ST_ERR;
                else
                    wait_cnt_next = wait_cnt_reg + 1'b1;
            end
            default: state_next = ST_ERR;
        endcase
    end

    always_comb begin
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        id_ex_hold   = 1'b0;
        ex_mem_hold  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        fwd_rs1_sel  = 2'b00;
        fwd_rs2_sel  = 2'b00;
        case (state_reg)
            ST_BOOT: begin
                pc_hold      = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                mem_wb_flush = 1'b1;
            end
            ST_ERR: begin
                pc_hold     = 1'b1;
                if_id_hold  = 1'b1;
                id_ex_hold  = 1'b1;
                ex_mem_hold = 1'b1;
            end
            default: begin
                fwd_rs1_sel = src_fwd[0];
                fwd_rs2_sel = src_fwd[1];
                if (st_bus) begin
                    pc_hold      = 1'b1;
                    if_id_hold   = 1'b1;
                    id_ex_hold   = 1'b1;
                    ex_mem_hold  = 1'b1;
                    mem_wb_flush = 1'b1;
                end else if (st_redir) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (st_load) begin
                    pc_hold     = 1'b1;
                    if_id_hold  = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end
        endcase
    end

    assign state_o     = state_reg;
    assign bus_timeout = (state_reg == ST_ERR);

`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] perf_cnt_reg [3];
    logic             perf_ev [3];

    assign perf_ev[0] = st_load;
    assign perf_ev[1] = st_bus;
    assign perf_ev[2] = st_redir;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_perf
            always_ff @(posedge cpu_clk or negedge cpu_rst) begin
                if (!cpu_rst)
                    perf_cnt_reg[gi] <= '0;
                else if (perf_ev[gi] && perf_cnt_reg[gi] != '1)
                    perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 1'b1;
            end
        end
    endgenerate

    assign perf_load_stall = perf_cnt_reg[0];
    assign perf_bus_wait   = perf_cnt_reg[1];
    assign perf_flush      = perf_cnt_reg[2];
`else
    assign perf_load_stall = '0;
    assign perf_bus_wait   = '0;
    assign perf_flush      = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table for RUN-state hazards/forwarding,
// hand sequences for boot, bridge wait, timeout trap and asynchronous reset.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 32;

    logic cpu_clk = 1'b0;
    logic cpu_rst;
    logic [4:0] id_rs1, id_rs2, ex_wr, mem_wr, wb_wr;
    logic id_rs1_re, id_rs2_re, ex_rf_we, ex_is_load, mem_rf_we, wb_rf_we;
    logic ex_redirect, mem_bus_req, bus_ack;
    logic pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
    logic if_id_flush, id_ex_flush, mem_wb_flush;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel, state_o;
    logic bus_timeout;
    logic [CNT_W-1:0] perf_load_stall, perf_bus_wait, perf_flush;

    pipe_hazard_ctrl #(.BOOT_CYCLES(2), .BUS_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_re(id_rs1_re), .id_rs2_re(id_rs2_re),
        .ex_wr(ex_wr), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load),
        .mem_wr(mem_wr), .mem_rf_we(mem_rf_we), .wb_wr(wb_wr), .wb_rf_we(wb_rf_we),
        .ex_redirect(ex_redirect), .mem_bus_req(mem_bus_req), .bus_ack(bus_ack),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold), .id_ex_hold(id_ex_hold),
        .ex_mem_hold(ex_mem_hold), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_flush(mem_wb_flush), .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .bus_timeout(bus_timeout), .state_o(state_o),
        .perf_load_stall(perf_load_stall), .perf_bus_wait(perf_bus_wait), .perf_flush(perf_flush)
    );

    always #5 cpu_clk = ~cpu_clk;

    // {pc, if_id_h, id_ex_h, ex_mem_h, if_id_f, id_ex_f, mem_wb_f, fwd1[1:0], fwd2[1:0]}
    logic [10:0] out_vec;
    assign out_vec = {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold,
                      if_id_flush, id_ex_flush, mem_wb_flush, fwd_rs1_sel, fwd_rs2_sel};

    localparam logic [10:0] V_BOOT  = 11'b1000_111_0000;
    localparam logic [10:0] V_BUS   = 11'b1111_001_0000;
    localparam logic [10:0] V_REDIR = 11'b0000_110_0000;
    localparam logic [10:0] V_ERR   = 11'b1111_000_0000;
    localparam logic [10:0] V_IDLE  = 11'b0000_000_0000;

    typedef struct {
        string       name;
        logic [4:0]  rs1, rs2;
        logic        re1, re2;
        logic [4:0]  exw;
        logic        exwe, exld;
        logic [4:0]  memw;
        logic        memwe;
        logic [4:0]  wbw;
        logic        wbwe;
        logic        redir;
        logic [10:0] exp;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    function automatic vec_t mk(string name, logic [4:0] rs1, logic [4:0] rs2, logic re1, logic re2,
                                logic [4:0] exw, logic exwe, logic exld, logic [4:0] memw, logic memwe,
                                logic [4:0] wbw, logic wbwe, logic redir, logic [10:0] exp);
        vec_t v;
        v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.re1 = re1; v.re2 = re2;
        v.exw = exw; v.exwe = exwe; v.exld = exld; v.memw = memw; v.memwe = memwe;
        v.wbw = wbw; v.wbwe = wbwe; v.redir = redir; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end else begin
            $display("ok   %s: %0h", name, got);
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; id_rs1_re = 0; id_rs2_re = 0;
        ex_wr = 0; ex_rf_we = 0; ex_is_load = 0;
        mem_wr = 0; mem_rf_we = 0; wb_wr = 0; wb_rf_we = 0;
        ex_redirect = 0; mem_bus_req = 0; bus_ack = 0;
    endtask

    vec_t vecs [14];

    initial begin
        vecs[0]  = mk("lu_rs1",      5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 11'b1100_010_0000);
        vecs[1]  = mk("lu_exwr0",    5, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 11'b0000_000_0000);
        vecs[2]  = mk("lu_re_off",   0, 5, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 11'b0000_000_0000);
        vecs[3]  = mk("fwd2_ex",     0, 3, 0, 1, 3, 1, 0, 3, 1, 3, 1, 0, 11'b0000_000_0001);
        vecs[4]  = mk("fwd2_mem",    0, 3, 0, 1, 3, 0, 0, 3, 1, 3, 1, 0, 11'b0000_000_0010);
        vecs[5]  = mk("fwd2_wb",     0, 3, 0, 1, 3, 0, 0, 3, 0, 3, 1, 0, 11'b0000_000_0011);
        vecs[6]  = mk("fwd2_rs0",    0, 0, 0, 1, 3, 0, 0, 3, 0, 3, 1, 0, 11'b0000_000_0000);
        vecs[7]  = mk("redir_lu",    5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 1, V_REDIR);
        vecs[8]  = mk("fwd1_wb",     7, 0, 1, 0, 0, 0, 0, 0, 0, 7, 1, 0, 11'b0000_000_1100);
        vecs[9]  = mk("fwd1_re_off", 7, 0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 11'b0000_000_0000);
        vecs[10] = mk("lu_mem_fwd",  4, 0, 1, 0, 4, 1, 1, 4, 1, 0, 0, 0, 11'b1100_010_1000);
        vecs[11] = mk("redir_only",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, V_REDIR);
        vecs[12] = mk("x0_all",      0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 11'b0000_000_0000);
        vecs[13] = mk("ld_no_we",    5, 0, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 11'b0000_000_0000);

        clear_inputs();
        cpu_rst = 1'b0;
        repeat (2) @(negedge cpu_clk);
        #1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_out", 32'(out_vec), 32'(V_BOOT));
        chk("rst_timeout", 32'(bus_timeout), 32'd0);
        chk("rst_perf", perf_load_stall | perf_bus_wait | perf_flush, 32'd0);

        // Boot hold: two BOOT cycles, RUN on the third.
        @(negedge cpu_clk); cpu_rst = 1'b1; #1;
        chk("boot1_out", 32'(out_vec), 32'(V_BOOT));
        @(negedge cpu_clk); #1;
        chk("boot2_state", 32'(state_o), 32'd0);
        chk("boot2_pc_hold", 32'(pc_hold), 32'd1);
        @(negedge cpu_clk); #1;
        chk("boot3_state", 32'(state_o), 32'd1);

        for (int i = 0; i < 14; i++) begin
            @(negedge cpu_clk);
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_rs1_re = vecs[i].re1; id_rs2_re = vecs[i].re2;
            ex_wr = vecs[i].exw; ex_rf_we = vecs[i].exwe; ex_is_load = vecs[i].exld;
            mem_wr = vecs[i].memw; mem_rf_we = vecs[i].memwe;
            wb_wr = vecs[i].wbw; wb_rf_we = vecs[i].wbwe;
            ex_redirect = vecs[i].redir;
            #1;
            chk(vecs[i].name, 32'(out_vec), 32'(vecs[i].exp));
        end

        // Bridge access acked on the third cycle, redirect held throughout.
        @(negedge cpu_clk);
        clear_inputs();
        mem_bus_req = 1; ex_redirect = 1; #1;
        chk("bus1_out", 32'(out_vec), 32'(V_BUS));
        chk("bus1_state", 32'(state_o), 32'd1);
        @(negedge cpu_clk); #1;
        chk("bus2_out", 32'(out_vec), 32'(V_BUS));
        chk("bus2_state", 32'(state_o), 32'd2);
        @(negedge cpu_clk); bus_ack = 1; #1;
        chk("bus3_ack_out", 32'(out_vec), 32'(V_REDIR));
        @(negedge cpu_clk); clear_inputs(); #1;
        chk("bus4_state", 32'(state_o), 32'd1);
        chk("bus4_out", 32'(out_vec), 32'(V_IDLE));

        // Fresh reset so the bus-wait counter starts from zero, then force a timeout.
        @(negedge cpu_clk); cpu_rst = 1'b0;
        @(negedge cpu_clk); cpu_rst = 1'b1;
        repeat (2) @(negedge cpu_clk);
        mem_bus_req = 1; #1;
        chk("to1_state", 32'(state_o), 32'd1);
        for (int c = 2; c <= 4; c++) begin
            @(negedge cpu_clk); #1;
            chk($sformatf("to%0d_state", c), 32'(state_o), 32'd2);
        end
        chk("to4_timeout", 32'(bus_timeout), 32'd0);
        @(negedge cpu_clk); #1;
        chk("to5_state", 32'(state_o), 32'd3);
        chk("to5_out", 32'(out_vec), 32'(V_ERR));
        chk("to5_timeout", 32'(bus_timeout), 32'd1);
        @(negedge cpu_clk); mem_bus_req = 0; bus_ack = 1; #1;
        @(negedge cpu_clk); #1;
        chk("to_sticky_state", 32'(state_o), 32'd3);
        chk("to_sticky_flag", 32'(bus_timeout), 32'd1);
`ifdef PIPE_HAZARD_PERF_EN
        chk("perf_bus_wait", perf_bus_wait, 32'd4);
`else
        chk("perf_bus_wait", perf_bus_wait, 32'd0);
`endif

        // Asynchronous reset mid-cycle from ERROR.
        #2 cpu_rst = 1'b0; #1;
        chk("arst_state", 32'(state_o), 32'd0);
        chk("arst_out", 32'(out_vec), 32'(V_BOOT));
        chk("arst_timeout", 32'(bus_timeout), 32'd0);
        chk("arst_perf", perf_bus_wait, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
